// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the RV32 multicycle control unit: FSM state
// encoding, opcode constants, ALUOp codes, and the select/control codes
// driven into the datapath. Also contains the immediate-format decoder,
// which is purely a function of the opcode.
// -----------------------------------------------------------------------------
package ctrl_pkg;

    // FSM states. Encodings 12-15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_AUIPC    = 4'd11
    } state_t;

    // Opcodes (InstrReg[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALUOp from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl
    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format is a pure opcode decode, valid in every state.
    function automatic logic [2:0] imm_dec(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_ITYPE: imm_dec = IMM_I;
            OP_STORE:          imm_dec = IMM_S;
            OP_BRANCH:         imm_dec = IMM_B;
            OP_JAL:            imm_dec = IMM_J;
            OP_AUIPC:          imm_dec = IMM_U;
            default:           imm_dec = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the multicycle datapath and its control unit.
//   Datapath -> control : op, funct3, funct7b5, Zero
//   Control  -> datapath: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//                         ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
//                         illegal_instr, state_dbg
// modport master: datapath side; modport slave: control unit side.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal_instr;
    logic [3:0] state_dbg;

    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, state_dbg
    );

    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation decode.
//   i_alu_op       ALUOp from the FSM (00 add, 01 sub, 10 use funct3)
//   i_funct3       InstrReg[14:12]
//   i_op5          InstrReg[5]; distinguishes R-type from I-type ALU ops
//   i_funct7b5     InstrReg[30]
//   o_alu_control  ALUControl to the datapath
// -----------------------------------------------------------------------------
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    // sub only for R-type: addi carries immediate bits in [30], so op[5]
    // must be set as well.
    logic w_rtype_sub;
    assign w_rtype_sub = i_op5 & i_funct7b5;

    always_comb begin
        o_alu_control = ALUC_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALUC_ADD;
            ALUOP_SUB: o_alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = w_rtype_sub ? ALUC_SUB : ALUC_ADD;
                    3'b010:  o_alu_control = ALUC_SLT;
                    3'b110:  o_alu_control = ALUC_OR;
                    3'b111:  o_alu_control = ALUC_AND;
                    default: o_alu_control = ALUC_ADD;
                endcase
            end
            default: o_alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Main control unit of the RV32 multicycle core: instruction-sequencing FSM,
// ALU decode (alu_decoder) and PC-write logic.
//   clk    core clock, rising edge
//   reset  synchronous, active-low; state forced to FETCH at a low edge
//   bus    multicycle_ctrl_if.slave: instruction fields and Zero in, all
//          datapath enables/selects, illegal_instr and state_dbg out
// Outputs are decoded combinationally from the registered state plus the
// instruction fields, so each state's controls appear the same cycle the
// state is entered.
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
)(
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.slave  bus
);

    state_t     r_state;
    logic [1:0] w_alu_op;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_takebr;

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_RTYPE:          r_state <= S_EXECR;
                        OP_ITYPE:          r_state <= S_EXECI;
                        OP_BRANCH:         r_state <= S_BRANCH;
                        OP_JAL:            r_state <= S_JAL;
                        OP_AUIPC:          r_state <= S_AUIPC;
                        default:           r_state <= S_FETCH;
                    endcase
                end
                // op[5] separates store (0100011) from load (0000011)
                S_MEMADR:   r_state <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: r_state <= S_FETCH;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                // jal writes the link (OldPC+4) through ALUWB
                S_JAL:      r_state <= S_ALUWB;
                S_AUIPC:    r_state <= S_ALUWB;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        bus.AdrSrc        = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ResultSrc     = RES_ALUOUT;
        bus.ALUSrcA       = SRCA_PC;
        bus.ALUSrcB       = SRCB_WD;
        bus.illegal_instr = 1'b0;
        w_alu_op          = ALUOP_ADD;
        w_pc_update       = 1'b0;
        w_branch          = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                w_pc_update   = 1'b1;
            end
            S_DECODE: begin
                // precompute branch target OldPC + ImmExt
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
                    OP_BRANCH, OP_JAL, OP_AUIPC: bus.illegal_instr = 1'b0;
                    default:                     bus.illegal_instr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_A;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECR: begin
                bus.ALUSrcA = SRCA_A;
                bus.ALUSrcB = SRCB_WD;
                w_alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                bus.ALUSrcA = SRCA_A;
                bus.ALUSrcB = SRCB_IMM;
                w_alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
            end
            S_BRANCH: begin
                // compare rs1 - rs2; target already in ALUOut from DECODE
                bus.ALUSrcA = SRCA_A;
                bus.ALUSrcB = SRCB_WD;
                w_alu_op    = ALUOP_SUB;
                w_branch    = 1'b1;
            end
            S_JAL: begin
                // PC <= ALUOut (target from DECODE); ALU makes OldPC + 4
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            S_AUIPC: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
            end
            default: ;
        endcase
    end

    assign bus.ImmSrc    = imm_dec(bus.op);
    assign bus.state_dbg = r_state;

    // ------------------------------------------------------------------
    // PC write: unconditional updates plus resolved branches. Unknown
    // branch funct3 values fall through as not-taken.
    // ------------------------------------------------------------------
    always_comb begin
        case (bus.funct3)
            3'b000:  w_takebr = bus.Zero;
            3'b001:  w_takebr = ~bus.Zero;
            default: w_takebr = 1'b0;
        endcase
    end

    assign bus.PCWrite = w_pc_update | (w_branch & w_takebr);

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (bus.funct3),
        .i_op5         (bus.op[5]),
        .i_funct7b5    (bus.funct7b5),
        .o_alu_control (bus.ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each instruction is run from FETCH
// back to FETCH while its per-cycle outputs are recorded; expectations come
// from an instruction-level model (latency, state path, write pulse counts,
// ALU operation of the execute cycle, immediate format).
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // per-cycle record of the last instruction run
    int obs_len;
    int obs_state [10];
    int obs_pcw   [10];
    int obs_srca  [10];
    int obs_srcb  [10];
    int obs_adr   [10];
    int obs_res   [10];
    int obs_alu   [10];

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4,
                   C_JAL = 5, C_AUIPC = 6, C_ILL = 7;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int classify(input logic [6:0] op);
        case (op)
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b0010111: return C_AUIPC;
            default:    return C_ILL;
        endcase
    endfunction

    task automatic get_seq(input int cls, output int len, output int seq [8]);
        for (int i = 0; i < 8; i++) seq[i] = 0;
        seq[1] = 1;
        case (cls)
            C_LW:    begin len = 5; seq[2] = 2; seq[3] = 3; seq[4] = 4; end
            C_SW:    begin len = 4; seq[2] = 2; seq[3] = 5; end
            C_R:     begin len = 4; seq[2] = 6; seq[3] = 8; end
            C_I:     begin len = 4; seq[2] = 7; seq[3] = 8; end
            C_BR:    begin len = 3; seq[2] = 9; end
            C_JAL:   begin len = 4; seq[2] = 10; seq[3] = 8; end
            C_AUIPC: begin len = 4; seq[2] = 11; seq[3] = 8; end
            default: begin len = 2; end
        endcase
    endtask

    // ALU operation the instruction needs in its third cycle
    function automatic int exp_alu(input int cls, input int f3, input int f7);
        int r;
        r = 0;
        if (cls == C_BR) r = 1;
        else if (cls == C_R || cls == C_I) begin
            case (f3)
                0: r = (cls == C_R && f7 == 1) ? 1 : 0;
                2: r = 5;
                6: r = 3;
                7: r = 2;
                default: r = 0;
            endcase
        end
        return r;
    endfunction

    function automatic int exp_imm(input logic [6:0] op);
        case (op)
            7'b0100011: return 1;
            7'b1100011: return 2;
            7'b1101111: return 3;
            7'b0010111: return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic int exp_pcw(input int cls, input int f3, input int z);
        int n;
        n = 1;
        if (cls == C_JAL) n++;
        if (cls == C_BR && ((f3 == 0 && z == 1) || (f3 == 1 && z == 0))) n++;
        return n;
    endfunction

    // ---------------- instruction runner ----------------
    // Starts with the DUT in FETCH and holds the instruction fields for the
    // whole instruction, as the instruction register would.
    task automatic run_instr(input string name, input logic [6:0] op,
                             input logic [2:0] f3, input logic f7, input logic z);
        int cls, elen, eseq [8];
        int n_rw, n_mw, n_pcw, n_ill, n_imm_bad, n_irw0;
        bit done;
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
        #1;
        cls = classify(op);
        get_seq(cls, elen, eseq);
        n_rw = 0; n_mw = 0; n_pcw = 0; n_ill = 0; n_imm_bad = 0; n_irw0 = 0;
        done = 0;
        obs_len = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            if (c > 0 && bus.state_dbg == 4'd0) begin
                obs_len = c;
                done = 1;
            end else begin
                obs_state[c] = int'(bus.state_dbg);
                obs_pcw[c]   = int'(bus.PCWrite);
                obs_srca[c]  = int'(bus.ALUSrcA);
                obs_srcb[c]  = int'(bus.ALUSrcB);
                obs_adr[c]   = int'(bus.AdrSrc);
                obs_res[c]   = int'(bus.ResultSrc);
                obs_alu[c]   = int'(bus.ALUControl);
                n_rw  += int'(bus.RegWrite);
                n_mw  += int'(bus.MemWrite);
                n_pcw += int'(bus.PCWrite);
                n_ill += int'(bus.illegal_instr);
                if (int'(bus.ImmSrc) != exp_imm(op)) n_imm_bad++;
                if (c == 0 && bus.IRWrite !== 1'b1) n_irw0++;
                step();
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: no return to FETCH within 10 cycles", name);
            return;
        end
        checks++;
        if (obs_len != elen) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, obs_len, elen);
        end else begin
            for (int c = 0; c < elen; c++) begin
                checks++;
                if (obs_state[c] != eseq[c]) begin
                    failures++;
                    $display("FAIL %s state[%0d]: got %0d expected %0d", name, c, obs_state[c], eseq[c]);
                end
            end
            if (elen > 2) begin
                checks++;
                if (obs_alu[2] != exp_alu(cls, int'(f3), int'(f7))) begin
                    failures++;
                    $display("FAIL %s alu_ctrl: got %0d expected %0d", name, obs_alu[2], exp_alu(cls, int'(f3), int'(f7)));
                end
            end
        end
        checks++;
        if (n_rw != ((cls == C_SW || cls == C_BR || cls == C_ILL) ? 0 : 1)) begin
            failures++;
            $display("FAIL %s regwrite_count: got %0d", name, n_rw);
        end
        checks++;
        if (n_mw != ((cls == C_SW) ? 1 : 0)) begin
            failures++;
            $display("FAIL %s memwrite_count: got %0d", name, n_mw);
        end
        checks++;
        if (n_pcw != exp_pcw(cls, int'(f3), int'(z))) begin
            failures++;
            $display("FAIL %s pcwrite_count: got %0d expected %0d", name, n_pcw, exp_pcw(cls, int'(f3), int'(z)));
        end
        checks++;
        if (n_ill != ((cls == C_ILL) ? 1 : 0)) begin
            failures++;
            $display("FAIL %s illegal_count: got %0d", name, n_ill);
        end
        checks++;
        if (n_imm_bad != 0 || n_irw0 != 0) begin
            failures++;
            $display("FAIL %s immsrc/irwrite: bad_imm_cycles=%0d fetch_irwrite_missing=%0d", name, n_imm_bad, n_irw0);
        end
    endtask

    // step until FETCH, bounded
    task automatic drain(input string name);
        int n;
        n = 0;
        while (bus.state_dbg != 4'd0 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (bus.state_dbg != 4'd0) begin
            failures++;
            $display("FAIL %s drain: stuck in state %0d", name, bus.state_dbg);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.state_dbg !== 4'd0 || bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1 ||
                bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: state=%0d irw=%b pcw=%b rw=%b mw=%b expected 0,1,1,0,0",
                         i, bus.state_dbg, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite);
            end
        end
        reset = 1'b1;
        step();
        checks++;
        if (bus.state_dbg !== 4'd1) begin
            failures++;
            $display("FAIL reset_release: state=%0d expected 1", bus.state_dbg);
        end
        drain("reset");
    endtask

    task automatic test_lw();
        run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0);
        checks++;
        if (obs_len == 5 && (obs_adr[3] != 1 || obs_res[4] != 1)) begin
            failures++;
            $display("FAIL lw_mem: memread adrsrc=%0d memwb resultsrc=%0d expected 1,1", obs_adr[3], obs_res[4]);
        end
        run_instr("sw", 7'b0100011, 3'b010, 1'b1, 1'b1);
    endtask

    task automatic test_alu_decode();
        run_instr("sub",      7'b0110011, 3'b000, 1'b1, 1'b0);
        run_instr("add",      7'b0110011, 3'b000, 1'b0, 1'b0);
        run_instr("addi_f7",  7'b0010011, 3'b000, 1'b1, 1'b0);
        run_instr("slt",      7'b0110011, 3'b010, 1'b0, 1'b0);
        run_instr("or",       7'b0110011, 3'b110, 1'b0, 1'b0);
        run_instr("andi",     7'b0010011, 3'b111, 1'b1, 1'b0);
        run_instr("auipc",    7'b0010111, 3'b101, 1'b1, 1'b0);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1);
        run_instr("beq_not",   7'b1100011, 3'b000, 1'b0, 1'b0);
        run_instr("bne_taken", 7'b1100011, 3'b001, 1'b0, 1'b0);
        run_instr("bne_not",   7'b1100011, 3'b001, 1'b0, 1'b1);
        run_instr("blt_unsup", 7'b1100011, 3'b100, 1'b0, 1'b1);
    endtask

    task automatic test_jal();
        run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0);
        checks++;
        if (obs_len == 4 && (obs_pcw[2] != 1 || obs_srca[2] != 1 || obs_srcb[2] != 2)) begin
            failures++;
            $display("FAIL jal_state: pcw=%0d srca=%0d srcb=%0d expected 1,1,2", obs_pcw[2], obs_srca[2], obs_srcb[2]);
        end
    endtask

    task automatic test_illegal();
        run_instr("illegal_lui", 7'b0110111, 3'b000, 1'b0, 1'b0);
        run_instr("illegal_zero", 7'b0000000, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        #1;
        step();
        step();
        checks++;
        if (bus.state_dbg !== 4'd2) begin
            failures++;
            $display("FAIL mid_reset_setup: state=%0d expected 2", bus.state_dbg);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_memadr: memwrite=%b expected 0", bus.MemWrite);
        end
        step();
        checks++;
        if (bus.state_dbg !== 4'd0 || bus.MemWrite !== 1'b0 || bus.RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_after: state=%0d mw=%b rw=%b expected 0,0,0",
                     bus.state_dbg, bus.MemWrite, bus.RegWrite);
        end
        reset = 1'b1;
        run_instr("sw_after_reset", 7'b0100011, 3'b010, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] ops [8];
        logic [6:0] op;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        ops[6] = 7'b0010111; ops[7] = 7'b0000000;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 7) op = 7'($urandom);
            else op = ops[$urandom_range(0, 6)];
            run_instr("random", op, 3'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_alu_decode();
        test_branch();
        test_jal();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // absolute safety bound on simulation time
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
